// File: rtl/spi_slave_sys_bridge.sv
// SPI responder (clock idles high, sample on rising edge, MSB first) that turns
// 8-bit command + 32-bit data frames into single system-bus reads and writes.
module spi_slave_sys_bridge #(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int unsigned ACK_TO    = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        spi_cs_i,
  input  logic        spi_clk_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_t,
  output logic [31:0] sys_addr,
  output logic [31:0] sys_wdata,
  output logic        sys_wen,
  output logic        sys_ren,
  input  logic [31:0] sys_rdata,
  input  logic        sys_ack,
  input  logic        sys_err,
  output logic        frm_err_o
);

  typedef enum logic [2:0] {
    IDLE, CMD, RD_REQ, RD_DATA, WR_DATA, WR_REQ, DONE
  } state_t;

  localparam logic [7:0] TO_LAST  = 8'(ACK_TO - 1);
  localparam logic [5:0] LAST_BIT = 6'd40;

  logic        cs_s1, cs_s2, cs_d;
  logic        sck_s1, sck_s2, sck_d;
  logic        mosi_s1, mosi_s2, mosi_d;
  state_t      state, state_n;
  logic [5:0]  bit_cnt, sh_cnt;
  logic [30:0] rx_sh;
  logic [31:0] tx_sh, tx_load;
  logic [6:0]  idx, cmd_idx;
  logic [7:0]  tmr;
  logic        abort_pend, miso_q;
  logic        cs_fall, cs_rise, rise_v, fall_v;
  logic        bus_wait, ack_ok, to_hit, bus_done;
  logic        start_rd, start_wr, err_n, abort_set;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      {cs_s1, cs_s2, cs_d}       <= 3'b111;
      {sck_s1, sck_s2, sck_d}    <= 3'b111;
      {mosi_s1, mosi_s2, mosi_d} <= 3'b000;
    end else begin
      {cs_s1, cs_s2, cs_d}       <= {spi_cs_i, cs_s1, cs_s2};
      {sck_s1, sck_s2, sck_d}    <= {spi_clk_i, sck_s1, sck_s2};
      {mosi_s1, mosi_s2, mosi_d} <= {spi_mosi_i, mosi_s1, mosi_s2};
    end
  end

  assign cs_fall = !cs_s2 && cs_d;
  assign cs_rise = cs_s2 && !cs_d;
  // SPI clock edges only count while cs is low, so an edge coincident with a cs rise is dropped.
  assign rise_v  = !cs_s2 && sck_s2 && !sck_d;
  assign fall_v  = !cs_s2 && !sck_s2 && sck_d;
  assign cmd_idx = {rx_sh[5:0], mosi_d};

  assign bus_wait = (state == RD_REQ) || (state == WR_REQ);
  assign ack_ok   = bus_wait && sys_ack;
  assign to_hit   = bus_wait && !sys_ack && (tmr == TO_LAST);
  assign bus_done = ack_ok || to_hit;
  // Data bits already clocked out while the read was pending are skipped.
  assign tx_load  = (to_hit ? 32'h0 : sys_rdata) << sh_cnt;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    err_n     = 1'b0;
    abort_set = 1'b0;
    case (state)
      IDLE: if (cs_fall) state_n = CMD;
      CMD: begin
        if (cs_rise) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (rise_v && bit_cnt == 6'd7) begin
          if (rx_sh[6]) begin
            state_n  = RD_REQ;
            start_rd = 1'b1;
          end else begin
            state_n = WR_DATA;
          end
        end
      end
      RD_REQ: begin
        abort_set = cs_rise && (bit_cnt != LAST_BIT);
        if (bus_done) begin
          err_n   = to_hit || sys_err || abort_pend || abort_set;
          state_n = (abort_pend || abort_set) ? IDLE : RD_DATA;
        end
      end
      RD_DATA: begin
        if (bit_cnt == LAST_BIT) begin
          state_n = DONE;
        end else if (cs_rise) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      WR_DATA: begin
        if (cs_rise) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (rise_v && bit_cnt == 6'd39) begin
          state_n  = WR_REQ;
          start_wr = 1'b1;
        end
      end
      WR_REQ: begin
        if (bus_done) begin
          state_n = DONE;
          err_n   = to_hit || sys_err;
        end
      end
      DONE: if (cs_s2) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      bit_cnt    <= '0;
      sh_cnt     <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      idx        <= '0;
      tmr        <= '0;
      abort_pend <= 1'b0;
      miso_q     <= 1'b0;
      sys_addr   <= '0;
      sys_wdata  <= '0;
      sys_wen    <= 1'b0;
      sys_ren    <= 1'b0;
      frm_err_o  <= 1'b0;
    end else begin
      sys_ren   <= start_rd;
      sys_wen   <= start_wr;
      frm_err_o <= err_n;

      if (state == IDLE) begin
        bit_cnt <= '0;
        rx_sh   <= '0;
      end else if (rise_v && state != DONE && bit_cnt != LAST_BIT) begin
        bit_cnt <= bit_cnt + 6'd1;
        rx_sh   <= {rx_sh[29:0], mosi_d};
      end

      if (state == CMD && rise_v && bit_cnt == 6'd7) idx <= cmd_idx;
      if (start_rd) sys_addr <= ADDR_BASE | {23'd0, cmd_idx, 2'b00};
      if (start_wr) begin
        sys_addr  <= ADDR_BASE | {23'd0, idx, 2'b00};
        sys_wdata <= {rx_sh, mosi_d};
      end

      if (start_rd || start_wr) tmr <= '0;
      else if (bus_wait)        tmr <= tmr + 8'd1;

      if (abort_set)     abort_pend <= 1'b1;
      else if (bus_done) abort_pend <= 1'b0;

      // MISO shifts on each falling edge; outside the read data phase it is held at 0.
      if (state == IDLE) begin
        tx_sh  <= '0;
        sh_cnt <= '0;
        miso_q <= 1'b0;
      end else if (state == RD_REQ && bus_done) begin
        if (fall_v) begin
          miso_q <= tx_load[31];
          tx_sh  <= {tx_load[30:0], 1'b0};
          sh_cnt <= sh_cnt + 6'd1;
        end else begin
          tx_sh <= tx_load;
        end
      end else if (fall_v && (state == RD_REQ || state == RD_DATA)) begin
        miso_q <= tx_sh[31];
        tx_sh  <= {tx_sh[30:0], 1'b0};
        sh_cnt <= sh_cnt + 6'd1;
      end else if (state != RD_REQ && state != RD_DATA) begin
        miso_q <= 1'b0;
      end
    end
  end

  assign spi_miso_o = miso_q;
  assign spi_miso_t = cs_s2;

endmodule

// File: tb/tb_spi_slave_sys_bridge.sv
// Bench for spi_slave_sys_bridge: acts as SPI master and bus responder, scoreboards
// bus strobes and checks MISO words, error pulses and tristate control.
`timescale 1ns/1ps
module tb_spi_slave_sys_bridge;
  localparam logic [31:0] ADDR_BASE = 32'h4000_0000;
  localparam int ACK_TO = 16;
  localparam int HP     = 24;
  localparam int CLK_NS = 10;
  localparam int NV     = 10;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        spi_cs_i = 1'b1;
  logic        spi_clk_i = 1'b1;
  logic        spi_mosi_i = 1'b0;
  logic        spi_miso_o, spi_miso_t;
  logic [31:0] sys_addr, sys_wdata;
  logic        sys_wen, sys_ren;
  logic [31:0] sys_rdata = '0;
  logic        sys_ack = 1'b0;
  logic        sys_err = 1'b0;
  logic        frm_err_o;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        rd;
    logic [6:0]  idx;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;
    logic        err;
    int          nbits;
    logic [31:0] exp_miso;
    int          exp_strobes;
    int          exp_ferr;
  } vec_t;

  bus_t  sb_q[$];
  vec_t  vecs[NV];
  string vname[NV];

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int ferr_cnt = 0;
  int strobe_cyc = 0;
  int ferr_cyc = 0;
  int resp_dly = -1;
  logic [31:0] resp_rdata = '0;
  logic        resp_err = 1'b0;

  spi_slave_sys_bridge #(.ADDR_BASE(ADDR_BASE), .ACK_TO(ACK_TO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .spi_cs_i(spi_cs_i), .spi_clk_i(spi_clk_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_t(spi_miso_t),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_err(sys_err),
    .frm_err_o(frm_err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Strobe scoreboard and error-pulse counter.
  initial begin
    bus_t e;
    forever begin
      @(negedge clk_i);
      if (rstn_i && (sys_ren || sys_wen)) begin
        strobe_cnt++;
        strobe_cyc = cyc;
        checkOutput("sb_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checkOutput("strobe_kind", {62'd0, sys_wen, sys_ren}, {62'd0, e.wr, !e.wr});
          checkOutput("sys_addr", 64'(sys_addr), 64'(e.addr));
          if (e.wr) checkOutput("sys_wdata", 64'(sys_wdata), 64'(e.wdata));
        end
      end
      if (frm_err_o) begin
        ferr_cnt++;
        ferr_cyc = cyc;
      end
    end
  end

  // Bus responder: acks resp_dly cycles after a strobe, never when resp_dly < 0.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rstn_i && (sys_ren || sys_wen) && resp_dly >= 0) begin
        repeat (resp_dly) @(negedge clk_i);
        sys_rdata = resp_rdata;
        sys_err   = resp_err;
        sys_ack   = 1'b1;
        @(negedge clk_i);
        sys_ack   = 1'b0;
        sys_err   = 1'b0;
        sys_rdata = '0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic spiBit(input logic d, output logic q);
    spi_clk_i  = 1'b0;
    spi_mosi_i = d;
    #(HP * CLK_NS);
    spi_clk_i = 1'b1;
    q = spi_miso_o;
    #(HP * CLK_NS);
  endtask

  task automatic applyStimulus(input string nm, input vec_t v);
    logic [39:0] word;
    logic [31:0] miso_w;
    logic [7:0]  cmd_miso;
    logic        q, t_low;
    bus_t        e;
    int          s0, f0;
    word       = {v.rd, v.idx, v.wdata};
    resp_dly   = v.ack_dly;
    resp_rdata = v.rdata;
    resp_err   = v.err;
    if (v.exp_strobes == 1) begin
      e.wr    = !v.rd;
      e.addr  = ADDR_BASE | {23'd0, v.idx, 2'b00};
      e.wdata = v.wdata;
      sb_q.push_back(e);
    end
    s0 = strobe_cnt;
    f0 = ferr_cnt;
    miso_w = '0;
    cmd_miso = '0;
    t_low = 1'b1;
    spi_cs_i = 1'b0;
    #(HP * CLK_NS);
    for (int b = 0; b < v.nbits; b++) begin
      spiBit((b < 40) ? word[39] : 1'b1, q);
      word = word << 1;
      if (b < 8) cmd_miso = {cmd_miso[6:0], q};
      else if (b < 40) miso_w = {miso_w[30:0], q};
      if (b == 0) t_low = spi_miso_t;
    end
    spi_cs_i = 1'b1;
    #(2 * HP * CLK_NS);
    checkOutput({nm, "/miso_t_low"}, 64'(t_low), 64'd0);
    checkOutput({nm, "/miso_t_high"}, 64'(spi_miso_t), 64'd1);
    checkOutput({nm, "/strobes"}, 64'(strobe_cnt - s0), 64'(v.exp_strobes));
    checkOutput({nm, "/frm_err"}, 64'(ferr_cnt - f0), 64'(v.exp_ferr));
    checkOutput({nm, "/sb_drained"}, 64'(sb_q.size()), 64'd0);
    if (v.nbits >= 8) checkOutput({nm, "/cmd_miso"}, 64'(cmd_miso), 64'd0);
    if (v.rd && v.nbits >= 40) checkOutput({nm, "/miso_word"}, 64'(miso_w), 64'(v.exp_miso));
    if (v.exp_strobes == 1 && v.ack_dly < 0)
      checkOutput({nm, "/timeout_lat"}, 64'(ferr_cyc - strobe_cyc), 64'(ACK_TO));
  endtask

  function automatic vec_t mkVec(input logic rd, input logic [6:0] idx, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int ack_dly, input logic err,
                                 input int nbits, input logic [31:0] exp_miso,
                                 input int exp_strobes, input int exp_ferr);
    vec_t v;
    v.rd = rd; v.idx = idx; v.wdata = wdata; v.rdata = rdata; v.ack_dly = ack_dly;
    v.err = err; v.nbits = nbits; v.exp_miso = exp_miso;
    v.exp_strobes = exp_strobes; v.exp_ferr = exp_ferr;
    return v;
  endfunction

  initial begin
    logic [7:0] cmd8;
    logic       q;
    int         s0, f0;

    vname[0] = "wr_basic";    vecs[0] = mkVec(0, 7'h0C, 32'h0000_0001, 32'h0,          2, 0, 40, 32'h0,          1, 0);
    vname[1] = "rd_basic";    vecs[1] = mkVec(1, 7'h14, 32'h0,          32'hA5A5_1234,  3, 0, 40, 32'hA5A5_1234,  1, 0);
    vname[2] = "rd_timeout";  vecs[2] = mkVec(1, 7'h05, 32'h0,          32'hFFFF_FFFF, -1, 0, 40, 32'h0,          1, 1);
    vname[3] = "wr_abort";    vecs[3] = mkVec(0, 7'h02, 32'h1234_5678, 32'h0,          2, 0, 20, 32'h0,          0, 1);
    vname[4] = "wr_deadbeef"; vecs[4] = mkVec(0, 7'h01, 32'hDEAD_BEEF, 32'h0,          1, 0, 40, 32'h0,          1, 0);
    vname[5] = "wr_48bit";    vecs[5] = mkVec(0, 7'h7F, 32'hCAFE_F00D, 32'h0,          2, 0, 48, 32'h0,          1, 0);
    vname[6] = "rd_buserr";   vecs[6] = mkVec(1, 7'h33, 32'h0,          32'h0F0F_5A5A,  0, 1, 40, 32'h0F0F_5A5A,  1, 1);
    vname[7] = "wr_timeout";  vecs[7] = mkVec(0, 7'h40, 32'h1357_2468, 32'h0,         -1, 0, 40, 32'h0,          1, 1);
    vname[8] = "rd_abort";    vecs[8] = mkVec(1, 7'h10, 32'h0,          32'h1111_2222,  4, 0, 12, 32'h0,          1, 1);
    vname[9] = "rd_ack_last"; vecs[9] = mkVec(1, 7'h7E, 32'h0,          32'h8000_0001, ACK_TO - 1, 0, 40, 32'h8000_0001, 1, 0);

    repeat (4) @(negedge clk_i);
    checkOutput("reset/addr_wdata", {sys_addr, sys_wdata}, 64'd0);
    checkOutput("reset/flags", {59'd0, sys_ren, sys_wen, frm_err_o, spi_miso_o, spi_miso_t}, 64'd1);
    rstn_i = 1'b1;
    repeat (4) @(negedge clk_i);

    for (int i = 0; i < NV; i++) applyStimulus(vname[i], vecs[i]);

    // Reset while a read is waiting for its ack: no error pulse afterwards.
    resp_dly = -1;
    sb_q.push_back(bus_t'{wr: 1'b0, addr: ADDR_BASE | 32'h84, wdata: 32'h0});
    s0 = strobe_cnt;
    f0 = ferr_cnt;
    cmd8 = 8'hA1;
    spi_cs_i = 1'b0;
    #(HP * CLK_NS);
    for (int b = 0; b < 7; b++) begin
      spiBit(cmd8[7], q);
      cmd8 = cmd8 << 1;
    end
    spi_clk_i  = 1'b0;
    spi_mosi_i = cmd8[7];
    #(HP * CLK_NS);
    spi_clk_i = 1'b1;
    repeat (8) @(negedge clk_i);
    checkOutput("rst_mid/ren_seen", 64'(strobe_cnt - s0), 64'd1);
    rstn_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_mid/addr_wdata", {sys_addr, sys_wdata}, 64'd0);
    checkOutput("rst_mid/flags", {59'd0, sys_ren, sys_wen, frm_err_o, spi_miso_o, spi_miso_t}, 64'd1);
    spi_cs_i = 1'b1;
    repeat (6) @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (ACK_TO + 10) @(negedge clk_i);
    checkOutput("rst_mid/no_err", 64'(ferr_cnt - f0), 64'd0);
    checkOutput("rst_mid/no_strobe", 64'(strobe_cnt - s0), 64'd1);
    applyStimulus("rd_after_rst", mkVec(1, 7'h2A, 32'h0, 32'h1357_9BDF, 2, 0, 40, 32'h1357_9BDF, 1, 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
